// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU between NUM_REQ requesters.
// Optional per-requester grant counters when ALU_SCHED_STATS_EN is defined.
module alu_req_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]  req_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [2:0]            alu_op,
  input  logic [31:0]           alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]     rr_next;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [OP_W-1:0]     sel_op;

  // First valid requester at or after rr_ptr, wrapping; constant indices only.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!grant_found && req_valid[i] &&
            (((int'(rr_ptr) + k) % int'(NUM_REQ)) == i)) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(i);
          grant_oh[i] = 1'b1;
        end
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_oh[i]) begin
        sel_a  = req_a[DATA_W*i +: DATA_W];
        sel_b  = req_b[DATA_W*i +: DATA_W];
        sel_op = req_op[OP_W*i +: OP_W];
      end
    end
  end

  always_comb begin
    rr_next = grant_idx + ID_W'(1);
    if (int'(grant_idx) == int'(NUM_REQ) - 1) begin
      rr_next = '0;
    end
  end

  // Accept is only offered while idle, so at most one op is ever in flight.
  always_comb begin
    req_ready = '0;
    if (state == IDLE) begin
      req_ready = grant_oh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            rsp_id <= grant_idx;
            rr_ptr <= rr_next;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  // Saturating handshake counters, one per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req_valid[i] && req_ready[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      grant_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed self-checking bench for alu_req_scheduler with a behavioural ALU model.
module tb_alu_req_scheduler;

  localparam int unsigned NR = 2;
  localparam int unsigned IW = 2;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*32-1:0]  req_a;
  logic [NR*32-1:0]  req_b;
  logic [NR*3-1:0]   req_op;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [2:0]        alu_op;
  logic [31:0]       alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [IW-1:0]     rsp_id;
  logic              busy;
`ifdef ALU_SCHED_STATS_EN
  logic [NR*16-1:0]  grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int id_seen [NR];

  alu_req_scheduler #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef ALU_SCHED_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    case (op)
      3'd0: return b + a;
      3'd1: return b - a;
      3'd2: return b << a;
      3'd3: return {31'b0, (b < a)};
      3'd4: return b ^ a;
      3'd5: return b >> a;
      3'd6: return b | a;
      default: return b & a;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  // One full op with rsp_ready=1: grant check, EXEC cycle, response cycle, back to IDLE.
  task automatic op_cycle(input int gid, input logic [31:0] exp_data, input bit drop,
                          input string tag);
    logic [NR-1:0] oh;
    oh = '0;
    oh[gid] = 1'b1;
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(oh));
    tick();
    if (drop) req_valid[gid] = 1'b0;
    #1;
    chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
    chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_data"}, rsp_data, exp_data);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(gid));
    if (rsp_id < IW'(NR)) id_seen[rsp_id]++;
    tick();
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(NR); i++) id_seen[i] = 0;
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req_ready", 32'(req_ready), 32'd0);
    chk("idle_no_req_busy", 32'(busy), 32'd0);

    // Single request: 7 + 5
    set_req(0, 32'd5, 32'd7, 3'd0);
    req_valid = 2'b01;
    #1;
    chk("single_alu_before", alu_a, 32'd0);
    op_cycle(0, 32'd12, 1'b1, "single");
    chk("single_alu_a_held", alu_a, 32'd5);
    chk("single_alu_b_held", alu_b, 32'd7);

    // Lone req1 (rr_ptr=1): 9 ^ 2; pointer returns to 0
    set_req(1, 32'd2, 32'd9, 3'd4);
    req_valid = 2'b10;
    op_cycle(1, 32'd11, 1'b1, "xor_req1");

    // Contention: 10-3 then 1<<4
    set_req(0, 32'd3, 32'd10, 3'd1);
    set_req(1, 32'd4, 32'd1, 3'd2);
    req_valid = 2'b11;
    op_cycle(0, 32'd7, 1'b1, "cont0");
    op_cycle(1, 32'd16, 1'b1, "cont1");

    // Backpressure on req1: 0x100 >> 4
    set_req(1, 32'd4, 32'h100, 3'd5);
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b01;
    set_req(0, 32'd1, 32'hFFFF_FFFF, 3'd3);
    tick();
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data", rsp_data, 32'h10);
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);

    // Unsigned compare: 0xFFFFFFFF < 1 is false
    op_cycle(0, 32'd0, 1'b1, "sltu");

    // Reset while in EXEC (rr_ptr=1, req1 granted)
    set_req(1, 32'd9, 32'd9, 3'd0);
    req_valid = 2'b10;
    #1;
    chk("rmid_grant", 32'(req_ready), 32'b10);
    tick();
    chk("rmid_busy_before", 32'(busy), 32'd1);
    chk("rmid_alu_a_before", alu_a, 32'd9);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_alu_a", alu_a, 32'd0);
    chk("rmid_alu_b", alu_b, 32'd0);
    chk("rmid_rsp_id", 32'(rsp_id), 32'd0);
    chk("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef ALU_SCHED_STATS_EN
    chk("rmid_grant_cnt", grant_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rmid_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Fairness: both valid for 12 grants, order must start at req0 and alternate
    for (int i = 0; i < int'(NR); i++) id_seen[i] = 0;
    set_req(0, 32'd1, 32'd2, 3'd0);
    set_req(1, 32'd1, 32'd6, 3'd6);
    req_valid = 2'b11;
    for (int g = 0; g < 12; g++) begin
      if ((g % 2) == 0) op_cycle(0, 32'd3, 1'b0, "fair");
      else              op_cycle(1, 32'd7, 1'b0, "fair");
    end
    chk("fair_count0", 32'(id_seen[0]), 32'd6);
    chk("fair_count1", 32'(id_seen[1]), 32'd6);
`ifdef ALU_SCHED_STATS_EN
    chk("stats_cnt0", 32'(grant_cnt[15:0]), 32'd6);
    chk("stats_cnt1", 32'(grant_cnt[31:16]), 32'd6);
`endif
    req_valid = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
